// File: rtl/hid_keycode_packer.sv
// hid_keycode_packer: collects a USB HID boot-keyboard report one byte per
// cycle. It checks the report's length, watches for rollover reports and for
// stalls, and packs the first four non-zero key slots into one keycode word.
// Optional build macro: ROLLOVER_CLEAR_EN. When it is defined, a rollover
// report clears keycode/modifiers instead of holding them.
`timescale 1ns/1ps

module hid_keycode_packer #(
    parameter int unsigned REPORT_BYTES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  ROLLOVER_CODE  = 8'h01
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic [31:0] keycode,
    output logic [7:0]  modifiers,
    output logic        keycode_update,
    output logic        report_error
);

    localparam int IDX_W = $clog2(REPORT_BYTES);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REPORT_BYTES - 1);
    localparam logic [IDX_W-1:0] FIRST_KEY = IDX_W'(2);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD,
        S_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;          // index of the last accepted byte
    logic [TMR_W-1:0] tmr_q, tmr_d;          // idle cycles since last accepted byte
    logic [31:0]      shadow_q, shadow_d;    // keycode word being assembled
    logic [7:0]       shmod_q, shmod_d;      // modifiers byte being assembled
    logic [2:0]       lanes_q, lanes_d;      // key lanes filled so far (0..4)
    logic             rollover_q, rollover_d;
    logic [31:0]      keycode_q, keycode_d;
    logic [7:0]       mod_q, mod_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;

    logic             accept;
    logic [IDX_W-1:0] cur_idx;
    logic             timeout_hit;

    // Only the single commit cycle refuses input.
    assign rx_ready    = (state_q != S_COMMIT);
    assign accept      = rx_valid && rx_ready;
    assign cur_idx     = idx_q + IDX_W'(1);
    assign timeout_hit = (tmr_q == TMR_LIMIT);

    assign keycode        = keycode_q;
    assign modifiers      = mod_q;
    assign keycode_update = upd_q;
    assign report_error   = err_q;

    // Next-state logic: report framing, key packing, timeout and commit.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        shadow_d   = shadow_q;
        shmod_d    = shmod_q;
        lanes_d    = lanes_q;
        rollover_d = rollover_q;
        keycode_d  = keycode_q;
        mod_d      = mod_q;
        upd_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (accept) begin
                    // Byte 0 (modifiers) opens a new report with a clean shadow.
                    shmod_d    = rx_data;
                    idx_d      = '0;
                    shadow_d   = '0;
                    lanes_d    = '0;
                    rollover_d = 1'b0;
                    if (rx_last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    tmr_d = '0;
                    idx_d = cur_idx;
                    if (cur_idx >= FIRST_KEY) begin
                        if (rx_data == ROLLOVER_CODE) begin
                            rollover_d = 1'b1;
                        end
                        if (rx_data != 8'h00 && lanes_q < 3'd4) begin
                            unique case (lanes_q[1:0])
                                2'd0: shadow_d[7:0]   = rx_data;
                                2'd1: shadow_d[15:8]  = rx_data;
                                2'd2: shadow_d[23:16] = rx_data;
                                2'd3: shadow_d[31:24] = rx_data;
                                default: ;
                            endcase
                            lanes_d = lanes_q + 3'd1;
                        end
                    end
                    if (rx_last) begin
                        if (cur_idx == LAST_IDX) begin
                            state_d = S_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cur_idx == LAST_IDX) begin
                        // The report is already full but has not ended, so it is too long.
                        state_d = S_DISCARD;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_DISCARD: begin
                if (accept) begin
                    tmr_d = '0;
                    if (rx_last) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
                if (rollover_q) begin
                    err_d = 1'b1;
`ifdef ROLLOVER_CLEAR_EN
                    // Consumers see "no keys pressed" rather than a stale snapshot.
                    keycode_d = '0;
                    mod_d     = '0;
                    upd_d     = 1'b1;
`endif
                end else begin
                    keycode_d = shadow_q;
                    mod_d     = shmod_q;
                    upd_d     = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial report.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmr_q      <= '0;
            shadow_q   <= '0;
            shmod_q    <= '0;
            lanes_q    <= '0;
            rollover_q <= 1'b0;
            keycode_q  <= '0;
            mod_q      <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here make every register sample the pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmr_q      <= tmr_d;
            shadow_q   <= shadow_d;
            shmod_q    <= shmod_d;
            lanes_q    <= lanes_d;
            rollover_q <= rollover_d;
            keycode_q  <= keycode_d;
            mod_q      <= mod_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_hid_keycode_packer.sv
// tb_hid_keycode_packer: drives directed and random reports into
// hid_keycode_packer. A report-level model predicts the outputs, and the
// bench compares them with the DUT on every cycle outside reset.
// Honours ROLLOVER_CLEAR_EN the same way the DUT does.
`timescale 1ns/1ps

module tb_hid_keycode_packer;

    localparam int         REP  = 8;
    localparam int         TO   = 1000;
    localparam logic [7:0] ROLL = 8'h01;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;
    logic [31:0] keycode;
    logic [7:0]  modifiers;
    logic        keycode_update;
    logic        report_error;

    hid_keycode_packer #(
        .REPORT_BYTES   (REP),
        .TIMEOUT_CYCLES (TO),
        .ROLLOVER_CODE  (ROLL)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_last        (rx_last),
        .rx_ready       (rx_ready),
        .keycode        (keycode),
        .modifiers      (modifiers),
        .keycode_update (keycode_update),
        .report_error   (report_error)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- report-level reference model ----------------
    logic [7:0]  rep_q[$];   // bytes of the report in progress
    bit          in_rep;
    int          idle_cnt;
    bit          commit_pend;
    logic [31:0] m_key;
    logic [7:0]  m_mod;
    bit          m_upd;
    bit          m_err;
    bit          m_ready;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rep_q.delete();
            in_rep      = 0;
            idle_cnt    = 0;
            commit_pend = 0;
            m_key       = '0;
            m_mod       = '0;
            m_upd       = 0;
            m_err       = 0;
        end else begin
            m_upd = 0;
            m_err = 0;
            if (commit_pend) begin
                logic [31:0] keys;
                bit          roll;
                int          n;
                commit_pend = 0;
                keys = '0;
                roll = 0;
                n    = 0;
                for (int i = 2; i < REP; i++) begin
                    if (rep_q[i] == ROLL) roll = 1;
                    if (rep_q[i] != 8'h00 && n < 4) begin
                        keys[n*8 +: 8] = rep_q[i];
                        n++;
                    end
                end
                if (roll) begin
                    m_err = 1;
`ifdef ROLLOVER_CLEAR_EN
                    m_key = '0;
                    m_mod = '0;
                    m_upd = 1;
`endif
                end else begin
                    m_key = keys;
                    m_mod = rep_q[0];
                    m_upd = 1;
                end
            end else if (rx_valid) begin
                idle_cnt = 0;
                if (!in_rep) begin
                    rep_q.delete();
                    rep_q.push_back(rx_data);
                    if (rx_last) m_err = 1;
                    else         in_rep = 1;
                end else begin
                    rep_q.push_back(rx_data);
                    if (rx_last) begin
                        in_rep = 0;
                        if (rep_q.size() == REP) commit_pend = 1;
                        else                     m_err = 1;
                    end
                end
            end else if (in_rep) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    m_err    = 1;
                    in_rep   = 0;
                    idle_cnt = 0;
                end
            end
        end
        m_ready = !commit_pend;
    end

    // ---------------- per-cycle compare and pulse tallies ----------------
    int err_seen = 0;
    int upd_seen = 0;

    always @(negedge Clk) begin
        if (!Reset) begin
            check("rx_ready",       32'(rx_ready),       32'(m_ready));
            check("keycode",        keycode,             m_key);
            check("modifiers",      32'(modifiers),      32'(m_mod));
            check("keycode_update", 32'(keycode_update), 32'(m_upd));
            check("report_error",   32'(report_error),   32'(m_err));
            if (report_error)   err_seen++;
            if (keycode_update) upd_seen++;
        end
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    logic [7:0] rep_buf[16];

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        bit rdy;
        rx_data  = d;
        rx_last  = last;
        rx_valid = 1'b1;
        guard    = 0;
        forever begin
            rdy = m_ready;
            @(posedge Clk);
            #2;
            if (rdy) break;
            guard++;
            if (guard > 4) begin
                n_cmp++;
                n_bad++;
                $display("FAIL handshake: byte %h not accepted after %0d cycles", d, guard);
                break;
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_rep(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            send_byte(rep_buf[i], i == len - 1);
        end
    endtask

    task automatic load8(input logic [63:0] bytes_msb_first);
        for (int i = 0; i < 8; i++) rep_buf[i] = bytes_msb_first[(7-i)*8 +: 8];
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int         e0, u0, kind, len;
        logic [31:0] k_hold;
        Reset    = 1'b1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("reset_keycode",   keycode,               32'h0);
        check("reset_modifiers", 32'(modifiers),        32'h0);
        check("reset_update",    32'(keycode_update),   32'h0);
        check("reset_error",     32'(report_error),     32'h0);
        check("reset_ready",     32'(rx_ready),         32'h1);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        idle(2);

        // Single arrow key.
        u0 = upd_seen;
        load8(64'h00_00_4F_00_00_00_00_00);
        send_rep(REP, 0);
        idle(3);
        check("t1_keycode",   keycode,              32'h0000004F);
        check("t1_modifiers", 32'(modifiers),       32'h00);
        check("t1_updates",   32'(upd_seen - u0),   32'd1);

        // Skipped zero slots, then overflow of the four lanes.
        load8(64'h02_00_00_52_1A_00_50_51);
        send_rep(REP, 0);
        idle(3);
        check("t2a_keycode",   keycode,        32'h51501A52);
        check("t2a_modifiers", 32'(modifiers), 32'h02);
        load8(64'h00_00_04_05_06_07_08_09);
        send_rep(REP, 0);
        idle(3);
        check("t2b_keycode", keycode, 32'h07060504);

        // Rollover report.
        load8(64'h00_00_4F_00_00_00_00_00);
        send_rep(REP, 0);
        idle(3);
        e0 = err_seen;
        u0 = upd_seen;
        load8(64'h00_00_01_01_01_01_01_01);
        send_rep(REP, 0);
        idle(3);
        check("roll_errors", 32'(err_seen - e0), 32'd1);
`ifdef ROLLOVER_CLEAR_EN
        k_hold = 32'h0;
        check("roll_keycode", keycode,                32'h0);
        check("roll_updates", 32'(upd_seen - u0),     32'd1);
`else
        k_hold = 32'h0000004F;
        check("roll_keycode", keycode,                32'h0000004F);
        check("roll_updates", 32'(upd_seen - u0),     32'd0);
`endif

        // Short report, then a long one.
        e0 = err_seen;
        load8(64'h00_00_4F_00_00_00_00_00);
        send_rep(5, 0);
        idle(3);
        check("short_errors",  32'(err_seen - e0), 32'd1);
        check("short_keycode", keycode,            k_hold);
        e0 = err_seen;
        for (int i = 0; i < 10; i++) rep_buf[i] = 8'h00;
        rep_buf[2] = 8'h4F;
        send_rep(10, 0);
        idle(3);
        check("long_errors",  32'(err_seen - e0), 32'd1);
        check("long_keycode", keycode,            k_hold);
        load8(64'h00_00_4F_00_00_00_00_00);
        send_rep(REP, 0);
        idle(3);
        check("after_bad_keycode", keycode, 32'h0000004F);

        // Stall inside a report.
        e0 = err_seen;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        idle(TO + 2);
        check("timeout_errors", 32'(err_seen - e0), 32'd1);
        load8(64'h00_00_50_00_00_00_00_00);
        send_rep(REP, 0);
        idle(3);
        check("timeout_keycode", keycode, 32'h00000050);

        // Reset during byte 5, then the tail of that report arrives.
        load8(64'h03_00_04_05_06_07_08_09);
        for (int i = 0; i < 5; i++) send_byte(rep_buf[i], 1'b0);
        rx_data  = rep_buf[5];
        rx_valid = 1'b1;
        #1 Reset = 1'b1;
        #1;
        check("arst_keycode",   keycode,             32'h0);
        check("arst_modifiers", 32'(modifiers),      32'h0);
        check("arst_update",    32'(keycode_update), 32'h0);
        check("arst_error",     32'(report_error),   32'h0);
        check("arst_ready",     32'(rx_ready),       32'h1);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        e0 = err_seen;
        send_byte(rep_buf[6], 1'b0);
        send_byte(rep_buf[7], 1'b1);
        idle(3);
        check("arst_tail_errors",  32'(err_seen - e0), 32'd1);
        check("arst_tail_keycode", keycode,            32'h0);

        // Random reports of every kind, with random gaps between bytes.
        for (int r = 0; r < 250; r++) begin
            kind = int'($urandom_range(0, 9));
            len  = REP;
            for (int i = 0; i < 16; i++)
                rep_buf[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(2, 255));
            rep_buf[0] = 8'($urandom_range(0, 255));
            rep_buf[1] = 8'h00;
            if (kind == 0)      len = int'($urandom_range(1, REP - 1));
            else if (kind == 1) len = int'($urandom_range(REP + 1, 12));
            else if (kind == 2) rep_buf[$urandom_range(2, REP - 1)] = ROLL;
            send_rep(len, 1);
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
